// File: rtl/uart_tx_word.sv
// 16-bit word transmitter: sends a word as two back-to-back 8N1 UART frames,
// low byte first. tx comes straight from a flop so the pin never glitches.
module uart_tx_word #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] BaudLast = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic            byte_sel_q, byte_sel_d;
    logic [15:0]     shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            accept;
    logic            bit_end;

    assign in_ready = (state_q == StIdle) || (state_q == StDone);
    assign busy     = ~in_ready;
    assign done     = (state_q == StDone);
    assign tx       = tx_q;
    assign accept   = in_valid & in_ready;
    assign bit_end  = (baud_q == BaudLast);

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        byte_sel_d = byte_sel_q;
        shift_d    = shift_q;
        tx_d       = tx_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                tx_d    = 1'b1;
                if (accept) begin
                    state_d    = StStart;
                    shift_d    = in_data;
                    byte_sel_d = 1'b0;
                    baud_d     = '0;
                    bit_d      = '0;
                    tx_d       = 1'b0;
                end
            end
            StStart: begin
                baud_d = bit_end ? '0 : baud_q + 1'b1;
                if (bit_end) begin
                    state_d = StData;
                    tx_d    = shift_q[0];
                end
            end
            StData: begin
                baud_d = bit_end ? '0 : baud_q + 1'b1;
                if (bit_end) begin
                    // Shifting after all 8 bits leaves the high byte in [7:0].
                    shift_d = {1'b0, shift_q[15:1]};
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                        bit_d   = '0;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[1];
                    end
                end
            end
            StStop: begin
                baud_d = bit_end ? '0 : baud_q + 1'b1;
                if (bit_end) begin
                    if (!byte_sel_q) begin
                        state_d    = StStart;
                        byte_sel_d = 1'b1;
                        tx_d       = 1'b0;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            baud_q     <= '0;
            bit_q      <= '0;
            byte_sel_q <= 1'b0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            byte_sel_q <= byte_sel_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_word.sv
// Bench for uart_tx_word: checks every tx cycle of each word against a frame
// model, on one instance with 4 clocks per bit and one with 2.
module tb_uart_tx_word;

    logic        clk = 1'b0;
    logic        rst_n4, rst_n2;
    logic [15:0] d4, d2;
    logic        v4, v2;
    logic        r4, tx4, b4, dn4;
    logic        r2, tx2, b2, dn2;

    int nassert = 0;
    int nfail   = 0;

    always #5 clk = ~clk;

    uart_tx_word #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n4), .in_data(d4), .in_valid(v4),
        .in_ready(r4), .tx(tx4), .busy(b4), .done(dn4)
    );

    uart_tx_word #(.CLKS_PER_BIT(2)) dut2 (
        .clk(clk), .rst_n(rst_n2), .in_data(d2), .in_valid(v2),
        .in_ready(r2), .tx(tx2), .busy(b2), .done(dn2)
    );

    // Serial bit idx (0..19) of a word: two frames of start, 8 data LSB first, stop.
    function automatic logic exp_bit(input logic [15:0] w, input int idx);
        logic [7:0] b;
        int pos;
        b   = (idx < 10) ? w[7:0] : w[15:8];
        pos = idx % 10;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return b[pos-1];
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nassert++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic [15:0] d);
        if (sel) begin
            v2 = v; d2 = d;
        end else begin
            v4 = v; d4 = d;
        end
    endtask

    task automatic sample(input bit sel, output logic t, output logic r, output logic b,
                          output logic dn);
        t  = sel ? tx2 : tx4;
        r  = sel ? r2 : r4;
        b  = sel ? b2 : b4;
        dn = sel ? dn2 : dn4;
    endtask

    task automatic chk_idle(input bit sel, input string tag);
        logic t, r, b, dn;
        sample(sel, t, r, b, dn);
        chk({tag, " tx"}, t, 1'b1);
        chk({tag, " in_ready"}, r, 1'b1);
        chk({tag, " busy"}, b, 1'b0);
        chk({tag, " done"}, dn, 1'b0);
    endtask

    task automatic idle_check(input bit sel, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk_idle(sel, $sformatf("idle%0d", i));
        end
    endtask

    // Present a word at a negedge while idle; the next posedge accepts it.
    task automatic start(input bit sel, input logic [15:0] w);
        logic t, r, b, dn;
        @(negedge clk);
        sample(sel, t, r, b, dn);
        chk($sformatf("ready before %h", w), r, 1'b1);
        drive(sel, 1'b1, w);
    endtask

    // Assumes the word was accepted at the latest posedge. mode 0: drop valid;
    // mode 1: keep valid with next word nd; mode 2: mid-frame pulse of 16'h1234.
    task automatic check_word(input bit sel, input int c, input logic [15:0] w,
                              input int mode, input logic [15:0] nd);
        logic t, r, b, dn, et;
        int   last;
        last = 20 * c + 1;
        for (int i = 1; i <= last; i++) begin
            @(negedge clk);
            sample(sel, t, r, b, dn);
            et = (i <= 20 * c) ? exp_bit(w, (i - 1) / c) : 1'b1;
            chk($sformatf("tx w=%h c=%0d cyc=%0d", w, c, i), t, et);
            chk($sformatf("in_ready w=%h cyc=%0d", w, i), r, i == last);
            chk($sformatf("busy w=%h cyc=%0d", w, i), b, i != last);
            chk($sformatf("done w=%h cyc=%0d", w, i), dn, i == last);
            if (i == 1) begin
                if (mode == 1) drive(sel, 1'b1, nd);
                else drive(sel, 1'b0, 16'($urandom));
            end
            if (mode == 2 && i == 30) drive(sel, 1'b1, 16'h1234);
            if (mode == 2 && i == 31) drive(sel, 1'b0, 16'($urandom));
        end
    endtask

    initial begin
        logic [15:0] w;
        rst_n4 = 1'b0; rst_n2 = 1'b0;
        v4 = 1'b0; v2 = 1'b0; d4 = '0; d2 = '0;

        // Reset holds outputs even with in_valid toggling.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(1'b0, i[0], 16'($urandom));
            drive(1'b1, i[0], 16'($urandom));
            #1;
            chk_idle(1'b0, $sformatf("rst4 %0d", i));
            chk_idle(1'b1, $sformatf("rst2 %0d", i));
        end
        @(negedge clk);
        drive(1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, '0);
        rst_n4 = 1'b1; rst_n2 = 1'b1;
        idle_check(1'b0, 2);

        // Single word.
        start(1'b0, 16'hA55A);
        check_word(1'b0, 4, 16'hA55A, 0, '0);

        // Back-to-back: second word accepted in the done cycle of the first.
        start(1'b0, 16'h0001);
        check_word(1'b0, 4, 16'h0001, 1, 16'hFFFF);
        check_word(1'b0, 4, 16'hFFFF, 0, '0);

        // Mid-frame valid is ignored; no extra frame afterwards.
        w = 16'($urandom);
        start(1'b0, w);
        check_word(1'b0, 4, w, 2, '0);
        idle_check(1'b0, 12);

        for (int k = 0; k < 3; k++) begin
            w = 16'($urandom);
            start(1'b0, w);
            check_word(1'b0, 4, w, 0, '0);
        end

        // Reset during the high byte's data bits (all zero, so tx is low there).
        start(1'b0, 16'h0000);
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (i == 1) drive(1'b0, 1'b0, '0);
        end
        chk("tx low before mid-frame reset", tx4, 1'b0);
        #1 rst_n4 = 1'b0;
        #1 chk_idle(1'b0, "async reset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_idle(1'b0, $sformatf("in reset %0d", i));
        end
        rst_n4 = 1'b1;
        idle_check(1'b0, 40);
        start(1'b0, 16'h00FF);
        check_word(1'b0, 4, 16'h00FF, 0, '0);

        // Minimum divider.
        start(1'b1, 16'h8001);
        check_word(1'b1, 2, 16'h8001, 0, '0);
        for (int k = 0; k < 3; k++) begin
            w = 16'($urandom);
            start(1'b1, w);
            check_word(1'b1, 2, w, (k == 0) ? 1 : 0, 16'h5AC3);
            if (k == 0) check_word(1'b1, 2, 16'h5AC3, 0, '0);
        end
        idle_check(1'b1, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule

// File: doc/uart_tx_word.md
Name: uart_tx_word

Overview:
- Transmit-side counterpart of the 16-bit UART receive interface.
- Accepts one 16-bit word through a valid/ready handshake and sends it over a UART serial line as two 8N1 frames: low byte first, then high byte.
- Sits between the DNN result/readback logic and the board TX pin. The host reassembles words in the same byte order that the receive path uses.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200 baud). Legal range is 2 or more. The internal counter width is clog2(CLKS_PER_BIT).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- in_data  in  16  word to transmit; captured at accept
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept a word
- tx  out  1  serial output; idle high
- busy  out  1  a frame is in progress
- done  out  1  one-cycle pulse after the high byte's stop bit completes

Behaviour:
- Reset values:
  - tx=1, in_ready=1, busy=0, done=0.
  - Shift register, bit counter, baud counter and byte select are all 0.
- Reset mid-transfer:
  - All outputs return to reset values immediately (asynchronous).
  - The word in flight is discarded and no done pulse is generated.
- Accept: in_valid=1 and in_ready=1 at a rising edge.
  - in_data is latched into an internal 16-bit register.
  - in_ready and busy update on that same edge: in_ready=0, busy=1.
  - in_valid while in_ready=0 is ignored. There is no buffering, and later changes to in_data have no effect.
- State machine: IDLE -> START -> DATA -> STOP -> (next byte: START | DONE) -> IDLE.
  - IDLE: tx=1, in_ready=1. On accept, go to START, select the low byte and clear the baud counter.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles. tx comes from the current shift register bit.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end:
    - If the low byte was selected, select the high byte, load its shift register and go to START. There is no idle gap between the two frames.
    - If the high byte was selected, go to DONE.
  - DONE: one cycle; done=1, tx=1, busy=0, in_ready=1. Then go to IDLE. A word may be accepted in the DONE cycle.
- Timing:
  - Let accept occur at edge k. tx is registered.
  - The low start bit drives cycles k+1 .. k+C, where C = CLKS_PER_BIT.
  - The full two-frame sequence occupies cycles k+1 .. k+20C.
  - done is high in cycle k+20C+1.
  - Back-to-back words therefore see exactly one idle-high cycle of tx between them.
- Baud counter:
  - Counts 0 .. C-1 and wraps.
  - A bit boundary occurs when the count equals C-1.
  - The bit index advances 0..7 and wraps with the DATA->STOP transition.
- tx must be glitch-free: it is driven from a flop only.
- busy equals NOT in_ready at all times.

Test Plan:
- Reset behaviour: hold rst_n=0 while toggling in_valid -> tx=1, in_ready=1, busy=0, done=0 throughout.
- Single word (C=4): send in_data=16'hA55A.
  - Bits sampled mid-bit on tx are 0,0,1,0,1,1,0,1,0,1 (low byte 0x5A), then 0,1,0,1,0,0,1,0,1,1 (high byte 0xA5).
  - done pulses exactly in cycle 81 after accept.
- Back-to-back (C=4): hold in_valid=1 with 16'h0001, then 16'hFFFF.
  - The second word is accepted in the done cycle of the first.
  - Exactly one tx=1 idle cycle separates the frames.
  - The second sequence is 0,11111111,1 twice.
- Ignored input: pulse in_valid with 16'h1234 mid-frame, then change in_data.
  - The transmitted bytes are unchanged.
  - No extra frame is sent and there is a single done pulse.
- Reset mid-frame: assert rst_n=0 during the DATA bits of the high byte.
  - tx=1 immediately and there is no done pulse.
  - After release, a new word 16'h00FF transmits correctly.
- Minimum divider: CLKS_PER_BIT=2 with 16'h8001 -> each bit lasts 2 cycles and done falls in cycle 41 after accept.
